// File: rtl/vgac_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and the counter type.
package vgac_pkg;

  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BACK   = 48;
  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FRONT  = 16;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BACK   = 33;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FRONT  = 10;

  localparam int H_TOTAL = DEF_H_SYNC + DEF_H_BACK + DEF_H_ACTIVE + DEF_H_FRONT;
  localparam int V_TOTAL = DEF_V_SYNC + DEF_V_BACK + DEF_V_ACTIVE + DEF_V_FRONT;
  localparam int H_START = DEF_H_SYNC + DEF_H_BACK;
  localparam int V_START = DEF_V_SYNC + DEF_V_BACK;

  typedef logic [9:0] cnt_t;

endpackage

// File: rtl/vgac_timing.sv
// Free-running horizontal/vertical position counters for the VGA raster.
module vgac_timing
  import vgac_pkg::*;
#(
  parameter int H_TOT = H_TOTAL,
  parameter int V_TOT = V_TOTAL
) (
  input  logic vga_clk,
  input  logic clrn,
  output cnt_t h_cnt,
  output cnt_t v_cnt
);

  localparam cnt_t H_LAST = cnt_t'(H_TOT - 1);
  localparam cnt_t V_LAST = cnt_t'(V_TOT - 1);

  cnt_t h_cnt_reg;
  cnt_t v_cnt_reg;

  // Reset wins unconditionally so a mid-frame reset drops the current line at once.
  always_ff @(posedge vga_clk) begin
    if (clrn) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= '0;
    end else if (h_cnt_reg == H_LAST) begin
      h_cnt_reg <= '0;
      v_cnt_reg <= (v_cnt_reg == V_LAST) ? cnt_t'(0) : v_cnt_reg + cnt_t'(1);
    end else begin
      h_cnt_reg <= h_cnt_reg + cnt_t'(1);
    end
  end

  assign h_cnt = h_cnt_reg;
  assign v_cnt = v_cnt_reg;

endmodule

// File: rtl/vgac.sv
// VGA controller: registered syncs, pixel addresses and read strobe, plus colour gated by the read strobe.
module vgac
  import vgac_pkg::*;
#(
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BACK   = DEF_H_BACK,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FRONT  = DEF_H_FRONT,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BACK   = DEF_V_BACK,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FRONT  = DEF_V_FRONT
) (
  input  logic        vga_clk,
  input  logic        clrn,
  input  logic [11:0] d_in,
  output logic [9:0]  row_addr,
  output logic [9:0]  col_addr,
  output logic        rdn,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hs,
  output logic        vs
);

  localparam int   H_TOT   = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int   V_TOT   = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam cnt_t H_FIRST = cnt_t'(H_SYNC + H_BACK);
  localparam cnt_t H_LAST  = cnt_t'(H_SYNC + H_BACK + H_ACTIVE - 1);
  localparam cnt_t V_FIRST = cnt_t'(V_SYNC + V_BACK);
  localparam cnt_t V_LAST  = cnt_t'(V_SYNC + V_BACK + V_ACTIVE - 1);

  cnt_t h_cnt;
  cnt_t v_cnt;

  vgac_timing #(
    .H_TOT (H_TOT),
    .V_TOT (V_TOT)
  ) u_timing (
    .vga_clk (vga_clk),
    .clrn    (clrn),
    .h_cnt   (h_cnt),
    .v_cnt   (v_cnt)
  );

  logic visible_next;
  logic hs_reg, vs_reg, rdn_reg;
  cnt_t row_reg, col_reg;
  logic [3:0] rgb_reg [3];

  assign visible_next = (h_cnt >= H_FIRST) && (h_cnt <= H_LAST) &&
                        (v_cnt >= V_FIRST) && (v_cnt <= V_LAST);

  always_ff @(posedge vga_clk) begin
    if (clrn) begin
      hs_reg  <= 1'b0;
      vs_reg  <= 1'b0;
      rdn_reg <= 1'b1;
      row_reg <= '0;
      col_reg <= '0;
    end else begin
      hs_reg  <= (h_cnt >= cnt_t'(H_SYNC));
      vs_reg  <= (v_cnt >= cnt_t'(V_SYNC));
      rdn_reg <= ~visible_next;
      row_reg <= v_cnt - V_FIRST;
      col_reg <= h_cnt - H_FIRST;
    end
  end

  // Colour follows the already-registered strobe, giving the pixel RAM one clock to answer.
  for (genvar gi = 0; gi < 3; gi++) begin : g_colour
    always_ff @(posedge vga_clk) begin
      if (clrn || rdn_reg) begin
        rgb_reg[gi] <= 4'h0;
      end else begin
        rgb_reg[gi] <= d_in[gi*4 +: 4];
      end
    end
  end

  assign hs       = hs_reg;
  assign vs       = vs_reg;
  assign rdn      = rdn_reg;
  assign row_addr = row_reg;
  assign col_addr = col_reg;
  assign r        = rgb_reg[0];
  assign g        = rgb_reg[1];
  assign b        = rgb_reg[2];

endmodule

// File: tb/tb_vgac.sv
// Self-checking bench for vgac on a shrunken raster, compared against a position-based raster model.
module tb_vgac;

  localparam int HS = 8, HB = 6, HA = 32, HF = 4;
  localparam int VS = 2, VB = 3, VA = 12, VF = 3;
  localparam int HT = HS + HB + HA + HF;
  localparam int VT = VS + VB + VA + VF;
  localparam int HST = HS + HB;
  localparam int VST = VS + VB;

  logic        vga_clk = 1'b0;
  logic        clrn = 1'b1;
  logic [11:0] d_in = '0;
  logic [9:0]  row_addr, col_addr;
  logic        rdn, hs, vs;
  logic [3:0]  r, g, b;

  vgac #(
    .H_SYNC (HS), .H_BACK (HB), .H_ACTIVE (HA), .H_FRONT (HF),
    .V_SYNC (VS), .V_BACK (VB), .V_ACTIVE (VA), .V_FRONT (VF)
  ) dut (
    .vga_clk  (vga_clk),
    .clrn     (clrn),
    .d_in     (d_in),
    .row_addr (row_addr),
    .col_addr (col_addr),
    .rdn      (rdn),
    .r        (r),
    .g        (g),
    .b        (b),
    .hs       (hs),
    .vs       (vs)
  );

  always #5 vga_clk = ~vga_clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Model: pos = clocks since reset release, i.e. the raster position the next output reflects.
  int   pos = 0;
  logic model_rdn = 1'b1;

  // Measurement state over observed DUT outputs.
  int   cyc, hs_fall, vs_fall, line_px, frame_px, max_row;
  logic hs_q, vs_q, rdn_q, first_pending;
  logic [9:0] col_q;

  task automatic measure(input logic rst);
    if (rst) begin
      cyc = 0; hs_fall = -1; vs_fall = -1; line_px = 0; frame_px = 0; max_row = -1;
      hs_q = 1'b0; vs_q = 1'b0; rdn_q = 1'b1; col_q = '0; first_pending = 1'b1;
      return;
    end
    cyc++;
    if (hs_q && !hs) begin
      if (hs_fall >= 0) check("hs_period", cyc - hs_fall, HT);
      hs_fall = cyc;
      if (line_px != 0) check("line_px", line_px, HA);
      line_px = 0;
    end
    if (!hs_q && hs && hs_fall >= 0) check("hs_low", cyc - hs_fall, HS);
    if (vs_q && !vs) begin
      if (vs_fall >= 0) check("vs_period", cyc - vs_fall, HT * VT);
      vs_fall = cyc;
      check("frame_px", frame_px, HA * VA);
      check("last_row", max_row, VA - 1);
      frame_px = 0; max_row = -1; first_pending = 1'b1;
    end
    if (!vs_q && vs && vs_fall >= 0) check("vs_low", cyc - vs_fall, VS * HT);
    if (!rdn) begin
      line_px++; frame_px++;
      if (int'(row_addr) > max_row) max_row = int'(row_addr);
      if (first_pending) begin
        check("first_row", row_addr, 0);
        check("first_col", col_addr, 0);
        first_pending = 1'b0;
      end
    end
    if (!rdn_q && rdn) check("last_col", col_q, HA - 1);
    hs_q = hs; vs_q = vs; rdn_q = rdn; col_q = col_addr;
  endtask

  task automatic step(input logic rst, input logic [11:0] din);
    int h, v, ehs, evs, erdn, ecol, erow, er, eg, eb;
    bit vis;
    clrn = rst;
    d_in = din;
    @(posedge vga_clk);
    #1;
    if (rst) begin
      ehs = 0; evs = 0; erdn = 1; ecol = 0; erow = 0; er = 0; eg = 0; eb = 0;
      pos = 0; model_rdn = 1'b1;
    end else begin
      h = pos % HT;
      v = (pos / HT) % VT;
      vis = (h >= HST) && (h < HST + HA) && (v >= VST) && (v < VST + VA);
      ehs = int'(h >= HS);
      evs = int'(v >= VS);
      erdn = int'(!vis);
      ecol = (h - HST) & 1023;
      erow = (v - VST) & 1023;
      er = model_rdn ? 0 : int'(din[3:0]);
      eg = model_rdn ? 0 : int'(din[7:4]);
      eb = model_rdn ? 0 : int'(din[11:8]);
      model_rdn = !vis;
      pos++;
    end
    check("hs", hs, ehs);
    check("vs", vs, evs);
    check("rdn", rdn, erdn);
    check("col_addr", col_addr, ecol);
    check("row_addr", row_addr, erow);
    check("r", r, er);
    check("g", g, eg);
    check("b", b, eb);
    measure(rst);
  endtask

  initial begin
    logic prev_rdn;

    for (int i = 0; i < 3; i++) step(1'b1, 12'($urandom));
    $display("reset: 3 clocks held");

    for (int i = 0; i < 2 * HT * VT + HT; i++) step(1'b0, 12'($urandom));
    $display("random: %0d clocks, pos=%0d", 2 * HT * VT + HT, pos);

    prev_rdn = rdn;
    for (int i = 0; i < HT * VT; i++) begin
      step(1'b0, 12'hFFF);
      if (i % 97 == 0) begin
        check("fff_r", r, prev_rdn ? 0 : 15);
        check("fff_b", b, prev_rdn ? 0 : 15);
      end
      prev_rdn = rdn;
    end
    $display("colour 12'hFFF: one frame");

    for (int i = 0; i < HT * VT; i++) begin
      step(1'b0, 12'h5A3);
      if (!prev_rdn && (i % 53 == 0)) begin
        check("5a3_r", r, 4'h3);
        check("5a3_g", g, 4'hA);
        check("5a3_b", b, 4'h5);
      end
      prev_rdn = rdn;
    end
    $display("colour 12'h5A3: one frame");

    while ((pos % (HT * VT)) != (VST + 2) * HT + HST + 3) step(1'b0, 12'($urandom));
    step(1'b1, 12'($urandom));
    $display("mid-frame reset at line %0d pixel %0d", VST + 2, HST + 3);
    for (int i = 0; i < HS + 2; i++) begin
      step(1'b0, 12'($urandom));
      check("restart_hs", hs, (i < HS) ? 0 : 1);
    end
    for (int i = 0; i < HT * VT + HT; i++) step(1'b0, 12'($urandom));
    $display("post-reset: one frame");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vgac.md
VGAC -- requirements
Module: vgac

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- H_SYNC, 96, hsync pulse width in clocks.
- H_BACK, 48, horizontal back porch in clocks.
- H_ACTIVE, 640, visible pixels per line.
- H_FRONT, 16, horizontal front porch in clocks.
- V_SYNC, 2, vsync pulse width in lines.
- V_BACK, 33, vertical back porch in lines.
- V_ACTIVE, 480, visible lines per frame.
- V_FRONT, 10, vertical front porch in lines.

REQ-002 Ports, one per line: name, direction, width, meaning.
- vga_clk  in  1  pixel clock, 25 MHz nominal; the only clock; all registers on its rising edge.
- clrn  in  1  reset; synchronous and active-high.
- d_in  in  12  pixel colour = {b[3:0], g[3:0], r[3:0]}.
- row_addr  out  10  visible line index, 0..479.
- col_addr  out  10  visible pixel index, 0..639.
- rdn  out  1  active-low read strobe; 0 only while the pixel position is visible.
- r, g, b  out  4 each  colour outputs.
- hs, vs  out  1 each  horizontal and vertical sync, active-low.

Function
REQ-003 h_cnt SHALL count 0..H_TOTAL-1 (H_TOTAL = 800) and wrap to 0.
REQ-004 v_cnt SHALL increment when h_cnt wraps, count 0..V_TOTAL-1 (V_TOTAL = 525), and wrap to 0 when both counters are at their maximum.
REQ-005 All outputs SHALL be registered and derived from the current counter values, so outputs lag the counters by 1 clock.
REQ-006 hs SHALL be 0 when h_cnt < H_SYNC, otherwise 1.
REQ-007 vs SHALL be 0 when v_cnt < V_SYNC, otherwise 1.
REQ-008 The position is visible when both hold:
- h_cnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] = [144, 783];
- v_cnt is in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1] = [35, 514].
REQ-009 rdn SHALL be 0 when the position is visible, otherwise 1.
REQ-010 col_addr SHALL be (h_cnt - 144) and row_addr SHALL be (v_cnt - 35), both as 10-bit unsigned modulo 1024 at all times; they are meaningful only while rdn = 0.
REQ-011 r, g, b SHALL be loaded each clock:
- if the currently registered rdn is 0: r = d_in[3:0], g = d_in[7:4], b = d_in[11:8];
- otherwise all three SHALL be 0.
This gives colour one clock of latency after the address, which suits a synchronous pixel RAM.
REQ-012 Frame timing SHALL be:
- hs period = 800 clocks, with low width = 96 clocks;
- vs period = 420000 clocks, with low width = 1600 clocks.
REQ-013 There SHALL be exactly 640 rdn-low clocks per visible line and 480 visible lines per frame.

Reset
REQ-014 While clrn = 1 at a rising edge:
- h_cnt and v_cnt SHALL be set to 0;
- rdn SHALL be 1;
- r, g, b SHALL be 0;
- hs and vs SHALL be 0;
- row_addr and col_addr SHALL be 0.
REQ-015 After clrn is released, counting SHALL start from (0,0) on the next edge, and the first output update SHALL reflect h_cnt = 0, v_cnt = 0.
REQ-016 Asserting reset mid-frame SHALL abort the frame immediately, with no partial-line completion.

Structure
REQ-017 Package vgac_pkg SHALL hold:
- the timing default localparams;
- the derived constants H_TOTAL, V_TOTAL, H_START = 144, V_START = 35;
- the 10-bit count type.
REQ-018 One sub-module, vgac_timing, SHALL contain the h/v counters. The output registering and colour gating SHALL remain in vgac.

Verification
REQ-019 Reset: hold clrn = 1 for 3 clocks -> rdn = 1, r = g = b = 0, hs = vs = 0, row_addr = col_addr = 0.
REQ-020 Sync timing: run 2 frames -> hs falling-edge spacing = 800 clocks with low width 96; vs falling-edge spacing = 420000 clocks with low width 1600.
REQ-021 Visible window: count rdn-low clocks -> 640 per line, 307200 per frame.
- At the first rdn = 0: row_addr = 0, col_addr = 0.
- At the last rdn = 0 of a line: col_addr = 639.
- At the last visible line: row_addr = 479.
REQ-022 Colour gating: d_in = 12'hFFF, then 12'h5A3.
- r = g = b = F while visible, 0 in blanking.
- For 12'h5A3: r = 3, g = A, b = 5, one clock after the corresponding rdn = 0.
REQ-023 Mid-frame reset: assert clrn at line 200, pixel 300 for 1 clock -> outputs take reset values, then the timing restarts from (0,0) and the next hs low begins 1 clock after release.
